control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle control FSM sitting directly downstream of the instruction register. It consumes the registered opcode plus the ALU `zero`/`sign` flags, sequences each instruction through IF/ID/EXE/MEM/WB, and drives every datapath enable and mux select. This includes `IRWre` back to the instruction register and `PCWre` to the PC.

## Interface
- No parameters.
- CLK  in  1  system clock; the state register advances on posedge.
- Reset  in  1  asynchronous, active-high; forces state to sIF.
- op  in  6  opcode from the instruction register.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result bit 31.
- State  out  4  current state, for debug.
- PCWre  out  1  PC write enable.
- IRWre  out  1  instruction register write enable.
- RegWre  out  1  register file write enable.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- ALUSrcA  out  1  0 = rs, 1 = shamt (zero-extended).
- ALUSrcB  out  1  0 = rt, 1 = extended immediate.
- DBDataSrc  out  1  0 = ALU result, 1 = memory data.
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DB data.
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend.
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd.
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs (jr), 11 = jump target.
- ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 110 slt, 111 xor.

## Operation
- Opcodes are fixed:
  - add 000000, sub 000001, addiu 000010
  - and 010000, andi 010001, ori 010010, xori 010011
  - sll 011000, slt 100110, slti 100111
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010, halt 111111
- States: sIF=0000, sID=0001, sEXE_AL=0110, sWB_AL=0111, sEXE_BR=0101, sEXE_LS=0010, sMEM=0011, sWB_L=0100, sHALT=1000.
- Transitions:
  - sIF → sID.
  - sID:
    - j, jr, jal → sIF.
    - halt → sHALT.
    - beq, bne, bltz → sEXE_BR.
    - lw, sw → sEXE_LS.
    - ALU ops → sEXE_AL.
    - Undefined opcode → sIF.
  - sEXE_AL → sWB_AL → sIF.
  - sEXE_BR → sIF.
  - sEXE_LS → sMEM.
  - sMEM: sw → sIF; lw → sWB_L.
  - sWB_L → sIF.
  - sHALT is absorbing; only Reset exits it.
- Outputs are combinational from State and op (plus the flags, for PCSrc).
- IRWre = 1 only in sIF.
- PCWre = 1 only in the final state of an instruction:
  - sID for j, jr, jal, or an undefined opcode.
  - sWB_AL.
  - sEXE_BR.
  - sMEM for sw.
  - sWB_L.
- RegWre = 1 in:
  - sWB_AL.
  - sWB_L.
  - sID for jal, with RegDst=00 and WrRegDSrc=0.
- mWR = 1 only in sMEM with op = sw; mRD = 1 only in sMEM with op = lw.
- PCSrc:
  - j, jal → 11; jr → 10.
  - Taken branch → 01. Taken means beq with zero=1, bne with zero=0, or bltz with sign=1.
  - Otherwise 00.
- Per-opcode selects:
  - ALUOp: add, addiu, lw, sw → 000; sub, beq, bne, bltz → 001; and, andi → 100; ori → 011; xori → 111; sll → 010; slt, slti → 110.
  - ALUSrcB = 1 for addiu, andi, ori, xori, slti, lw, sw.
  - ALUSrcA = 1 for sll only.
  - ExtSel = 0 for andi, ori, xori; otherwise 1.
  - RegDst = 10 for R-type (add, sub, and, slt, sll) and 01 for I-type writers.
  - DBDataSrc = 1 for lw.
  - WrRegDSrc = 1 for everything except jal.
- Selects are held stable for every cycle of an instruction, because IR contents are stable after sIF.

## Timing
- Cycles per instruction:
  - j, jr, jal: 2.
  - Branch: 3.
  - ALU ops and sw: 4.
  - lw: 5.
  - Undefined opcode: 2.
  - halt: infinite.
- Reset asserted at any time, including mid-instruction or in sHALT:
  - State becomes 0000 immediately, without waiting for a clock edge.
  - While Reset is high, PCWre, IRWre, RegWre and mWR are forced to 0; all other outputs are 0.
- After Reset deasserts, the first posedge leaves sIF. IRWre is 1 during that first sIF cycle.
- The branch decision samples `zero` and `sign` in sEXE_BR, in the same cycle that PCWre is asserted.
- Flags are ignored in every other state.
- No output may glitch to a write enable outside its listed state. Enables are decoded from State only, qualified by op.

## Test plan
- add (op 000000) after reset:
  - State sequence 0000 → 0001 → 0110 → 0111 → 0000.
  - RegWre=1 only in 0111, with RegDst=10 and ALUOp=000.
  - PCWre=1 only in 0111.
- lw (110001) followed by sw (110000):
  - lw takes 5 cycles: mRD=1 in 0011, then RegWre=1 with DBDataSrc=1 in 0100.
  - sw takes 4 cycles: mWR=1 in 0011 with PCWre=1, and RegWre stays 0.
- beq (110100):
  - With zero=1 in 0101: PCSrc=01, PCWre=1.
  - Repeated with zero=0: PCSrc=00.
  - bne with zero=0: PCSrc=01.
  - bltz with sign=1: PCSrc=01.
- jal (111010), then jr (111001):
  - Each takes 2 cycles.
  - jal in 0001: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
  - jr: PCSrc=10.
- halt (111111), then Reset asserted mid-sEXE_AL of a later run:
  - After halt, State holds 1000 with PCWre=0 for at least 10 cycles.
  - Reset returns State to 0000 asynchronously, with all enables 0 while Reset is high.
- Undefined opcode 101010: sID → sIF with PCWre=1, PCSrc=00, RegWre=0, mWR=0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multi-cycle control FSM for the IF/ID/EXE/MEM/WB datapath.
// The state register resets asynchronously. Every output is decoded
// combinationally from the current state and the registered opcode, and is
// forced to zero while Reset is high.
module control_unit (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       sign,
    output logic [3:0] State,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       DBDataSrc,
    output logic       WrRegDSrc,
    output logic       ExtSel,
    output logic [1:0] RegDst,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTI  = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_L   = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    state_t state, state_next;

    logic is_alu, is_branch, is_jump, is_ls, taken;

    // Opcode classification shared by next-state and output decode.
    always_comb begin
        is_alu    = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_ls     = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI,
            OP_ORI, OP_XORI, OP_SLL, OP_SLT, OP_SLTI: is_alu    = 1'b1;
            OP_BEQ, OP_BNE, OP_BLTZ:                  is_branch = 1'b1;
            OP_J, OP_JR, OP_JAL:                      is_jump   = 1'b1;
            OP_SW, OP_LW:                             is_ls     = 1'b1;
            default: ;
        endcase
        taken = ((op == OP_BEQ)  &&  zero) ||
                ((op == OP_BNE)  && !zero) ||
                ((op == OP_BLTZ) &&  sign);
    end

    // State register with asynchronous reset to instruction fetch.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= S_IF;
        else       state <= state_next;
    end

    // Next-state sequencing through the instruction phases.
    always_comb begin
        state_next = S_IF;
        unique case (state)
            S_IF: state_next = S_ID;
            S_ID: begin
                if (op == OP_HALT) state_next = S_HALT;
                else if (is_branch) state_next = S_EXE_BR;
                else if (is_ls)     state_next = S_EXE_LS;
                else if (is_alu)    state_next = S_EXE_AL;
                else                state_next = S_IF;
            end
            S_EXE_AL: state_next = S_WB_AL;
            S_WB_AL:  state_next = S_IF;
            S_EXE_BR: state_next = S_IF;
            S_EXE_LS: state_next = S_MEM;
            S_MEM:    state_next = (op == OP_LW) ? S_WB_L : S_IF;
            S_WB_L:   state_next = S_IF;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IF;
        endcase
    end

    assign State = state;

    // Datapath enables and selects; everything held at zero during Reset.
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        ExtSel    = 1'b0;
        RegDst    = 2'b00;
        PCSrc     = 2'b00;
        ALUOp     = 3'b000;
        if (!Reset) begin
            // Selects depend on the opcode only, so they stay constant
            // across all cycles of one instruction.
            ALUSrcA   = (op == OP_SLL);
            ALUSrcB   = (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) ||
                        (op == OP_XORI)  || (op == OP_SLTI) || is_ls;
            DBDataSrc = (op == OP_LW);
            WrRegDSrc = (op != OP_JAL);
            ExtSel    = !((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI));
            unique case (op)
                OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL:  RegDst = 2'b10;
                OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
                OP_SLTI, OP_LW:                          RegDst = 2'b01;
                default:                                 RegDst = 2'b00;
            endcase
            unique case (op)
                OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: ALUOp = 3'b001;
                OP_AND, OP_ANDI:                 ALUOp = 3'b100;
                OP_ORI:                          ALUOp = 3'b011;
                OP_XORI:                         ALUOp = 3'b111;
                OP_SLL:                          ALUOp = 3'b010;
                OP_SLT, OP_SLTI:                 ALUOp = 3'b110;
                default:                         ALUOp = 3'b000;
            endcase
            if ((op == OP_J) || (op == OP_JAL))        PCSrc = 2'b11;
            else if (op == OP_JR)                      PCSrc = 2'b10;
            else if ((state == S_EXE_BR) && taken)     PCSrc = 2'b01;

            IRWre = (state == S_IF);
            mRD   = (state == S_MEM) && (op == OP_LW);
            mWR   = (state == S_MEM) && (op == OP_SW);
            PCWre = ((state == S_ID) && !is_alu && !is_branch && !is_ls &&
                     (op != OP_HALT)) ||
                    (state == S_WB_AL) || (state == S_EXE_BR) ||
                    ((state == S_MEM) && (op == OP_SW)) ||
                    (state == S_WB_L);
            RegWre = (state == S_WB_AL) || (state == S_WB_L) ||
                     ((state == S_ID) && (op == OP_JAL));
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed instruction sequences checked every cycle against
// an instruction-level model (cycle index within instruction -> outputs).
module tb_control_unit;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] op;
    logic       zero, sign;
    logic [3:0] State;
    logic       PCWre, IRWre, RegWre, mRD, mWR;
    logic       ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp;

    int total = 0;
    int bad   = 0;

    control_unit dut (
        .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .sign(sign),
        .State(State), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
        .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .ExtSel(ExtSel),
        .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp)
    );

    always #5 CLK = ~CLK;

    // Vector layout: State, PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
    // DBDataSrc, WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp.
    logic [20:0] act;
    assign act = {State, PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
                  DBDataSrc, WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp};

    // Instruction-level model: k is the cycle index within the instruction,
    // k=0 is the fetch cycle.
    function automatic logic [20:0] model(input logic [5:0] o, input logic z,
                                          input logic s, input int unsigned k);
        logic jmp, br, alu, lw, sw, hlt, tk;
        int unsigned len;
        logic [3:0] st;
        logic pcw, irw, rw, rd, wr, a, b, db, wd, ex;
        logic [1:0] dst, pcs;
        logic [2:0] aop;
        jmp = o inside {6'b111000, 6'b111001, 6'b111010};
        br  = o inside {6'b110100, 6'b110101, 6'b110110};
        alu = o inside {6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                        6'b010010, 6'b010011, 6'b011000, 6'b100110, 6'b100111};
        lw  = (o == 6'b110001);
        sw  = (o == 6'b110000);
        hlt = (o == 6'b111111);
        if (br)             len = 3;
        else if (alu || sw) len = 4;
        else if (lw)        len = 5;
        else if (hlt)       len = 1000;
        else                len = 2;
        if (k == 0)      st = 4'd0;
        else if (k == 1) st = 4'd1;
        else if (hlt)    st = 4'd8;
        else if (br)     st = 4'd5;
        else if (alu)    st = (k == 2) ? 4'd6 : 4'd7;
        else             st = 4'd2 + 4'(k - 2);
        irw = (k == 0);
        pcw = !hlt && (k == len - 1);
        rw  = ((alu || lw) && (k == len - 1)) || ((o == 6'b111010) && (k == 1));
        rd  = lw && (k == 3);
        wr  = sw && (k == 3);
        tk  = ((o == 6'b110100) && z) || ((o == 6'b110101) && !z) ||
              ((o == 6'b110110) && s);
        if (o == 6'b111000 || o == 6'b111010) pcs = 2'b11;
        else if (o == 6'b111001)              pcs = 2'b10;
        else if (br && tk && k == 2)          pcs = 2'b01;
        else                                  pcs = 2'b00;
        a   = (o == 6'b011000);
        b   = o inside {6'b000010, 6'b010001, 6'b010010, 6'b010011, 6'b100111} || lw || sw;
        db  = lw;
        wd  = (o != 6'b111010);
        ex  = !(o inside {6'b010001, 6'b010010, 6'b010011});
        if (o inside {6'b000000, 6'b000001, 6'b010000, 6'b100110, 6'b011000})
            dst = 2'b10;
        else if ((alu && !(o inside {6'b000000, 6'b000001, 6'b010000, 6'b100110, 6'b011000})) || lw)
            dst = 2'b01;
        else
            dst = 2'b00;
        case (o)
            6'b000001, 6'b110100, 6'b110101, 6'b110110: aop = 3'b001;
            6'b010000, 6'b010001:                       aop = 3'b100;
            6'b010010:                                  aop = 3'b011;
            6'b010011:                                  aop = 3'b111;
            6'b011000:                                  aop = 3'b010;
            6'b100110, 6'b100111:                       aop = 3'b110;
            default:                                    aop = 3'b000;
        endcase
        return {st, pcw, irw, rw, rd, wr, a, b, db, wd, ex, dst, pcs, aop};
    endfunction

    task automatic check(input string name, input logic [20:0] got, input logic [20:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b (State got %0d want %0d)",
                     name, got, want, got[20:17], want[20:17]);
        end
    endtask

    // Entered at posedge+1 with the DUT in fetch; runs n cycles of one
    // instruction, comparing just before each falling edge. Flags are
    // inverted outside the branch-execute cycle to show they are ignored.
    task automatic run_instr(input string name, input logic [5:0] o,
                             input logic z, input logic s, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            op   = o;
            zero = (k == 2) ? z : ~z;
            sign = (k == 2) ? s : ~s;
            #3;
            check($sformatf("%s k=%0d", name, k), act, model(o, zero, sign, k));
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        Reset = 1'b1;
        op    = 6'b000000;
        zero  = 1'b0;
        sign  = 1'b0;

        // Hand-computed pins on the model itself.
        check("pin add wb",  model(6'b000000, 0, 0, 3),
              {4'd7, 5'b10100, 5'b00011, 2'b10, 2'b00, 3'b000});
        check("pin beq tk",  model(6'b110100, 1, 0, 2),
              {4'd5, 5'b10000, 5'b00011, 2'b00, 2'b01, 3'b001});
        check("pin jal id",  model(6'b111010, 0, 0, 1),
              {4'd1, 5'b10100, 5'b00001, 2'b00, 2'b11, 3'b000});
        check("pin lw wb",   model(6'b110001, 0, 0, 4),
              {4'd4, 5'b10100, 5'b01111, 2'b01, 2'b00, 3'b000});
        check("pin sw mem",  model(6'b110000, 0, 0, 3),
              {4'd3, 5'b10001, 5'b01011, 2'b00, 2'b00, 3'b000});
        check("pin undef",   model(6'b101010, 0, 0, 1),
              {4'd1, 5'b10000, 5'b00011, 2'b00, 2'b00, 3'b000});

        #2;
        check("reset0", act, '0);
        @(posedge CLK);
        #1;
        check("reset1", act, '0);
        Reset = 1'b0;

        run_instr("add",   6'b000000, 0, 0, 4);
        run_instr("lw",    6'b110001, 0, 0, 5);
        run_instr("sw",    6'b110000, 0, 0, 4);
        run_instr("beq1",  6'b110100, 1, 0, 3);
        run_instr("beq0",  6'b110100, 0, 0, 3);
        run_instr("bne0",  6'b110101, 0, 0, 3);
        run_instr("bne1",  6'b110101, 1, 0, 3);
        run_instr("bltz1", 6'b110110, 0, 1, 3);
        run_instr("bltz0", 6'b110110, 1, 0, 3);
        run_instr("jal",   6'b111010, 0, 0, 2);
        run_instr("jr",    6'b111001, 0, 0, 2);
        run_instr("j",     6'b111000, 0, 0, 2);
        run_instr("undef", 6'b101010, 0, 0, 2);
        run_instr("sub",   6'b000001, 0, 0, 4);
        run_instr("addiu", 6'b000010, 0, 0, 4);
        run_instr("and",   6'b010000, 0, 0, 4);
        run_instr("andi",  6'b010001, 0, 0, 4);
        run_instr("ori",   6'b010010, 0, 0, 4);
        run_instr("xori",  6'b010011, 0, 0, 4);
        run_instr("sll",   6'b011000, 0, 0, 4);
        run_instr("slt",   6'b100110, 0, 0, 4);
        run_instr("slti",  6'b100111, 0, 0, 4);
        run_instr("halt",  6'b111111, 0, 0, 14);

        // Reset out of the halt state, applied between clock edges.
        check("halt held", act, model(6'b111111, 1, 1, 14));
        Reset = 1'b1;
        #1;
        check("reset in halt", act, '0);
        @(posedge CLK);
        #1;
        check("reset in halt held", act, '0);
        Reset = 1'b0;

        // Reset in the middle of an ALU execute cycle.
        run_instr("add part", 6'b000000, 0, 0, 2);
        check("add exe before reset", act, model(6'b000000, 0, 0, 2));
        Reset = 1'b1;
        #1;
        check("reset mid exe", act, '0);
        @(posedge CLK);
        #1;
        check("reset mid exe held", act, '0);
        Reset = 1'b0;

        run_instr("add after", 6'b000000, 0, 0, 4);
        run_instr("lw after",  6'b110001, 0, 0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
